aes_round_ctrl: RTL
===================

# aes_round_ctrl

Iterative AES encryption round controller. Accepts one 128-bit plaintext block through a valid/ready handshake and holds the cipher state register. It sequences the initial AddRoundKey, then NUM_ROUNDS round iterations through the external combinational round datapath (sub_bytes -> shift_rows -> mix_columns), with mix_columns bypassed on the final round. It fetches round keys by index from the key-expansion block and returns the ciphertext through a second valid/ready handshake.

## Interface

Parameters:
- DATA_WIDTH, 128, block and round-key width; only 128 is supported.
- NUM_ROUNDS, 10, number of cipher rounds; legal values are 10, 12 and 14.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  plaintext offered.
- in_ready  out  1  controller can accept plaintext.
- in_data  in  DATA_WIDTH  plaintext block.
- key_idx  out  4  round-key index requested from key expansion (0..NUM_ROUNDS).
- key_valid  in  1  round_key is valid for the current key_idx.
- round_key  in  DATA_WIDTH  round key for key_idx.
- dp_state  out  DATA_WIDTH  state register, driven to the round datapath input.
- dp_final  out  1  final round; the datapath bypasses mix_columns.
- dp_result  in  DATA_WIDTH  datapath output, combinational from dp_state and dp_final.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer accepts ciphertext.
- out_data  out  DATA_WIDTH  ciphertext; equal to the state register.
- busy  out  1  high in any state other than IDLE.

## Operation

- FSM states: IDLE, INIT, ROUND, DONE. Round counter rnd has 4 bits.
- IDLE:
  - in_ready=1 and key_idx=0.
  - On in_valid&in_ready: state<=in_data, rnd<=0, go to INIT.
- INIT:
  - key_idx=0.
  - If key_valid: state<=state^round_key, rnd<=1, go to ROUND.
  - Otherwise hold all registers.
- ROUND:
  - key_idx=rnd and dp_final=(rnd==NUM_ROUNDS).
  - If key_valid: state<=dp_result^round_key.
    - If rnd==NUM_ROUNDS, go to DONE.
    - Otherwise rnd<=rnd+1.
  - If key_valid=0: stall, with state, rnd and outputs held.
- DONE:
  - out_valid=1 and out_data=state.
  - key_idx=0, so key expansion can prefetch.
  - On out_valid&out_ready: go to IDLE.
  - out_data stays stable while out_valid=1 and out_ready=0.
- in_ready is high only in IDLE, so there is no overlap between blocks. in_valid is ignored in all other states.
- dp_final is 0 in every state except ROUND with rnd==NUM_ROUNDS.
- rnd never exceeds NUM_ROUNDS; it does not wrap.
- Reset in any state:
  - Next state IDLE.
  - state<=0 and rnd<=0.
  - Any in-flight block is discarded with no output.
- Reset values of outputs: in_ready=1, out_valid=0, busy=0, key_idx=0, dp_final=0, dp_state=0, out_data=0.

## Timing

- All outputs are registered-state decodes; there is no combinational path from in_valid or out_ready to any output.
- Latency with key_valid held high:
  - Accept at edge E0.
  - INIT applies at E1.
  - Rounds 1..NUM_ROUNDS apply at E2..E(NUM_ROUNDS+1).
  - out_valid asserts after E(NUM_ROUNDS+1): 11 cycles after acceptance for NUM_ROUNDS=10.
- Each key_valid=0 cycle in INIT or ROUND adds exactly one cycle of latency.
- A block completes the output handshake at the same edge it is accepted out of DONE. in_ready rises in the following cycle.
- Minimum spacing between accepts is NUM_ROUNDS+3 cycles.

## Test plan

- FIPS-197 C.1 vector: in_data=00112233445566778899aabbccddeeff, key expansion from key 000102030405060708090a0b0c0d0e0f, key_valid tied high, out_ready=1.
  - Expect out_data=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Expect out_valid exactly 11 cycles after the accept edge, high for 1 cycle.
- Key stalls: same vector with key_valid low for 3 cycles in INIT and 2 cycles at rnd=5.
  - Same ciphertext, latency 16 cycles.
  - dp_state and key_idx stable during stalls.
- Output backpressure: out_ready=0 for 7 cycles after out_valid.
  - out_valid and out_data held constant and in_ready=0 throughout.
  - Accepted on the first cycle with out_ready=1.
  - in_ready rises on the next cycle.
- dp_final checks:
  - dp_final=1 only while key_idx=10 in ROUND; 0 in every other state.
  - in_valid pulsed during ROUND and DONE is ignored; the block is unchanged.
- Reset mid-round: assert rst for 1 cycle at rnd=6.
  - Next cycle: in_ready=1, busy=0, out_valid=0, key_idx=0, dp_state=0.
  - A fresh block then produces the correct ciphertext.
- Back-to-back: two vectors, with in_valid held high and out_ready=1.
  - Both ciphertexts correct, in order.
  - Second accepted 13 cycles after the first.

Source files
------------

// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath bundle for the iterative AES round controller.
//   master : the controller side (drives in_ready, key_idx, dp_state,
//            dp_final, out_valid, out_data, busy)
//   slave  : the environment side (plaintext source, key expansion,
//            round datapath, ciphertext sink)
interface aes_round_ctrl_if #(
  parameter int DATA_WIDTH = 128
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [3:0]            key_idx;
  logic                  key_valid;
  logic [DATA_WIDTH-1:0] round_key;
  logic [DATA_WIDTH-1:0] dp_state;
  logic                  dp_final;
  logic [DATA_WIDTH-1:0] dp_result;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  busy;

  modport master (
    input  in_valid, in_data, key_valid, round_key, dp_result, out_ready,
    output in_ready, key_idx, dp_state, dp_final, out_valid, out_data, busy
  );

  modport slave (
    output in_valid, in_data, key_valid, round_key, dp_result, out_ready,
    input  in_ready, key_idx, dp_state, dp_final, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption round controller.
// Accepts one plaintext block, applies the initial AddRoundKey, then runs
// NUM_ROUNDS iterations through an external combinational round datapath
// (mix_columns bypassed on the last round), fetching round keys by index,
// and returns the ciphertext through an output valid/ready handshake.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - aes_round_ctrl_if.master: plaintext in (in_valid/in_ready/in_data),
//          key fetch (key_idx/key_valid/round_key), round datapath
//          (dp_state/dp_final/dp_result), ciphertext out
//          (out_valid/out_ready/out_data), busy status
module aes_round_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_ROUNDS = 10
) (
  input logic              clk,
  input logic              rst,
  aes_round_ctrl_if.master bus
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} fsm_t;

  fsm_t                  fsm;
  logic [3:0]            rnd;
  logic [DATA_WIDTH-1:0] state;

  // Output flops are loaded with the decode of the next FSM state, so every
  // output is a pure register with no path from in_valid or out_ready.
  logic       in_ready_q;
  logic       out_valid_q;
  logic       busy_q;
  logic       dp_final_q;
  logic [3:0] key_idx_q;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.dp_final  = dp_final_q;
  assign bus.key_idx   = key_idx_q;
  assign bus.dp_state  = state;
  assign bus.out_data  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= IDLE;
      state       <= '0;
      rnd         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      dp_final_q  <= 1'b0;
      key_idx_q   <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone completes it
          if (bus.in_valid) begin
            state      <= bus.in_data;
            rnd        <= '0;
            fsm        <= INIT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            key_idx_q  <= '0;
          end
        end
        INIT: begin
          if (bus.key_valid) begin
            state      <= state ^ bus.round_key;
            rnd        <= 4'd1;
            fsm        <= ROUND;
            key_idx_q  <= 4'd1;
            dp_final_q <= (LAST_RND == 4'd1);
          end
        end
        ROUND: begin
          // a missing key stalls everything, including the key index
          if (bus.key_valid) begin
            state <= bus.dp_result ^ bus.round_key;
            if (rnd == LAST_RND) begin
              fsm         <= DONE;
              key_idx_q   <= '0;
              dp_final_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              rnd        <= rnd + 4'd1;
              key_idx_q  <= rnd + 4'd1;
              dp_final_q <= ((rnd + 4'd1) == LAST_RND);
            end
          end
        end
        DONE: begin
          // key_idx sits at 0 here so key expansion can prefetch round 0
          if (bus.out_ready) begin
            fsm         <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
